// File: rtl/bdd_sbox_dr_sequencer.sv
// Controller for the dual-rail precharged BDD S-box slices: drives select rails and pre,
// sequences precharge/evaluate, and collects the dual-rail result with protocol checking.
module bdd_sbox_dr_sequencer #(
   parameter int unsigned PRE_CYCLES   = 2,
   parameter int unsigned EVAL_TIMEOUT = 8,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic [3:0] select,
   output logic [3:0] select_bar,
   output logic       pre,
   input  logic [3:0] u_out,
   input  logic [3:0] c_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int unsigned CntMax = (PRE_CYCLES > EVAL_TIMEOUT) ? PRE_CYCLES : EVAL_TIMEOUT;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {StIdle, StPre, StEval, StHold, StReturn} state_e;

   state_e                        state_q, state_d;
   logic [CntW-1:0]               cnt_q, cnt_d;
   logic [3:0]                    nib_q, nib_d;
   logic [3:0]                    out_data_q, out_data_d;
   logic                          fault_q, fault_d;
   logic [1:0]                    code_q, code_d;
   logic                          set_fault;
   logic [1:0]                    cause;
   logic                          in_ready_q, pre_q, out_valid_q;
   logic [3:0]                    select_q, select_bar_q;
   logic                          pre_d;
   logic [SYNC_STAGES-1:0][3:0]   u_sync_q, c_sync_q;
   logic [3:0]                    us, cs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_sync_q <= '0;
         c_sync_q <= '0;
      end else begin
         u_sync_q[0] <= u_out;
         c_sync_q[0] <= c_out;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            u_sync_q[i] <= u_sync_q[i-1];
            c_sync_q[i] <= c_sync_q[i-1];
         end
      end
   end

   assign us = u_sync_q[SYNC_STAGES-1];
   assign cs = c_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nib_d      = nib_q;
      out_data_d = out_data_q;
      fault_d    = fault_q;
      code_d     = code_q;
      set_fault  = 1'b0;
      cause      = 2'd0;
      unique case (state_q)
         StIdle: begin
            // in_ready_q is low in the first cycle after reset, so gate on it
            if (in_valid && in_ready_q) begin
               nib_d   = in_data;
               cnt_d   = '0;
               state_d = StPre;
            end
         end
         StPre: begin
            if (cnt_q == CntW'(PRE_CYCLES - 1)) begin
               if (|{us, cs}) begin
                  set_fault = 1'b1;
                  cause     = 2'd1;
                  state_d   = StIdle;
               end else begin
                  cnt_d   = '0;
                  state_d = StEval;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StEval: begin
            // Both-rails-high outranks completion and timeout
            if (|(us & cs)) begin
               set_fault = 1'b1;
               cause     = 2'd2;
               state_d   = StReturn;
            end else if (&(us ^ cs)) begin
               out_data_d = us;
               state_d    = StHold;
            end else if (cnt_q == CntW'(EVAL_TIMEOUT - 1)) begin
               set_fault = 1'b1;
               cause     = 2'd3;
               state_d   = StReturn;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHold: begin
            if (out_ready) state_d = StReturn;
         end
         StReturn: begin
            if (!(|{us, cs})) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (set_fault && !fault_q) begin
         fault_d = 1'b1;
         code_d  = cause;
      end
   end

   // Outputs are registered from the next state so reset values are all-zero
   assign pre_d = (state_d == StEval) || (state_d == StHold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         nib_q        <= '0;
         out_data_q   <= '0;
         fault_q      <= 1'b0;
         code_q       <= 2'd0;
         in_ready_q   <= 1'b0;
         pre_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         select_q     <= '0;
         select_bar_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         nib_q        <= nib_d;
         out_data_q   <= out_data_d;
         fault_q      <= fault_d;
         code_q       <= code_d;
         in_ready_q   <= (state_d == StIdle);
         pre_q        <= pre_d;
         out_valid_q  <= (state_d == StHold);
         select_q     <= pre_d ? nib_d : 4'h0;
         select_bar_q <= pre_d ? ~nib_d : 4'h0;
      end
   end

   assign in_ready   = in_ready_q;
   assign pre        = pre_q;
   assign select     = select_q;
   assign select_bar = select_bar_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign fault      = fault_q;
   assign fault_code = code_q;

endmodule
